// File: rtl/i2c_reg_ctrl.sv
// Pointer-addressed register bank that sits behind i2c_slave's byte-level flags.
// I2C writes set and auto-increment the pointer; reads stream from it without moving it.
module i2c_reg_ctrl #(
  parameter int unsigned                REG_COUNT = 16,
  parameter int unsigned                ADDR_W    = $clog2(REG_COUNT),
  parameter logic [REG_COUNT-1:0]       WR_MASK   = '1,
  parameter logic [REG_COUNT*8-1:0]     RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     slv_busy,
  input  logic                     slv_data_available,
  input  logic                     slv_data_request,
  input  logic [7:0]               slv_data_o,
  output logic [7:0]               slv_data_i,
  input  logic                     sys_we,
  input  logic [ADDR_W-1:0]        sys_waddr,
  input  logic [7:0]               sys_wdata,
  output logic                     sys_drop,
  output logic [REG_COUNT*8-1:0]   reg_flat,
  output logic [REG_COUNT-1:0]     reg_wr_pulse,
  output logic [ADDR_W-1:0]        ptr
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOpen = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StRd   = 2'd3;

  logic                 bsy_q, bsy_qq, dav_q, dav_qq, req_q, req_qq;
  logic                 bsy_rise, bsy_fall, dav_rise, req_rise;
  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 req_seen_q, req_seen_d;
  logic [7:0]           data_i_q, data_i_d;
  logic [7:0]           regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] pulse_q, pulse_d;
  logic                 load_rd, i2c_we;

  // Busy stages reset high so a transaction already running at reset release is not a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bsy_q  <= 1'b1;
      bsy_qq <= 1'b1;
      dav_q  <= 1'b0;
      dav_qq <= 1'b0;
      req_q  <= 1'b0;
      req_qq <= 1'b0;
    end else begin
      bsy_q  <= slv_busy;
      bsy_qq <= bsy_q;
      dav_q  <= slv_data_available;
      dav_qq <= dav_q;
      req_q  <= slv_data_request;
      req_qq <= req_q;
    end
  end

  assign bsy_rise = bsy_q & ~bsy_qq;
  assign bsy_fall = ~bsy_q & bsy_qq;
  assign dav_rise = dav_q & ~dav_qq;
  assign req_rise = req_q & ~req_qq;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_ptr_d   = rd_ptr_q;
    req_seen_d = req_seen_q;
    data_i_d   = data_i_q;
    load_rd    = 1'b0;
    i2c_we     = 1'b0;
    case (state_q)
      StIdle: begin
        rd_ptr_d   = ptr_q;
        req_seen_d = 1'b0;
        if (bsy_rise) state_d = StOpen;
      end
      StOpen: begin
        if (dav_rise) begin
          ptr_d   = slv_data_o[ADDR_W-1:0];
          state_d = StWr;
        end else if (req_rise) begin
          // A second request before any written byte means this is a read.
          load_rd    = 1'b1;
          req_seen_d = 1'b1;
          if (req_seen_q) state_d = StRd;
        end
      end
      StWr: begin
        if (dav_rise) begin
          i2c_we = WR_MASK[ptr_q];
          ptr_d  = ptr_q + ADDR_W'(1);
        end
      end
      StRd: begin
        if (req_rise) load_rd = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (load_rd) begin
      data_i_d = regs_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (bsy_fall) state_d = StIdle;
  end

  always_comb begin
    pulse_d = '0;
    if (i2c_we) pulse_d[ptr_q] = 1'b1;
  end

  assign sys_drop = sys_we & i2c_we & (sys_waddr == ptr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rd_ptr_q   <= '0;
      req_seen_q <= 1'b0;
      data_i_q   <= 8'h00;
      pulse_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      req_seen_q <= req_seen_d;
      data_i_q   <= data_i_d;
      pulse_q    <= pulse_d;
    end
  end

  // The I2C assignment comes last so it wins a same-register collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= RESET_VAL[8*i +: 8];
    end else begin
      if (sys_we) regs_q[sys_waddr] <= sys_wdata;
      if (i2c_we) regs_q[ptr_q] <= slv_data_o;
    end
  end

  always_comb begin
    reg_flat = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) reg_flat[8*i +: 8] = regs_q[i];
  end

  assign slv_data_i   = data_i_q;
  assign reg_wr_pulse = pulse_q;
  assign ptr          = ptr_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: two instances (full mask, reg4 protected) share one stimulus
// and are checked every cycle against a transaction-level model plus literal spot checks.
module tb_i2c_reg_ctrl;

  localparam logic [127:0] RV     = 128'h3C_0000;
  localparam logic [15:0]  MASK_B = 16'hFFEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         busy = 1'b0, dav = 1'b0, req = 1'b0;
  logic [7:0]   sdo = 8'h00;
  logic         sys_we = 1'b0;
  logic [3:0]   sys_waddr = 4'h0;
  logic [7:0]   sys_wdata = 8'h00;

  logic [7:0]   dout_a, dout_b;
  logic         drop_a, drop_b;
  logic [127:0] flat_a, flat_b;
  logic [15:0]  pulse_a, pulse_b;
  logic [3:0]   ptr_a, ptr_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  i2c_reg_ctrl #(.REG_COUNT(16), .WR_MASK(16'hFFFF), .RESET_VAL(RV)) dut_a (
    .clk(clk), .rst(rst_n), .slv_busy(busy), .slv_data_available(dav),
    .slv_data_request(req), .slv_data_o(sdo), .slv_data_i(dout_a),
    .sys_we(sys_we), .sys_waddr(sys_waddr), .sys_wdata(sys_wdata), .sys_drop(drop_a),
    .reg_flat(flat_a), .reg_wr_pulse(pulse_a), .ptr(ptr_a)
  );

  i2c_reg_ctrl #(.REG_COUNT(16), .WR_MASK(MASK_B), .RESET_VAL(RV)) dut_b (
    .clk(clk), .rst(rst_n), .slv_busy(busy), .slv_data_available(dav),
    .slv_data_request(req), .slv_data_o(sdo), .slv_data_i(dout_b),
    .sys_we(sys_we), .sys_waddr(sys_waddr), .sys_wdata(sys_wdata), .sys_drop(drop_b),
    .reg_flat(flat_b), .reg_wr_pulse(pulse_b), .ptr(ptr_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: transaction phase, pointer, registers ----------------
  typedef enum int {MIdle, MOpen, MWr, MRd} mphase_e;
  mphase_e     ph;
  int unsigned m_ptr, m_rd, n_req;
  logic [7:0]  m_reg [2][16];
  logic [15:0] m_pulse [2];
  logic [7:0]  m_dout [2];
  bit prv_bsy, prv_dav, prv_req;
  // Flag edges are seen at one clock and act at the next (two-stage capture).
  bit pd_bsy_rise, pd_bsy_fall, pd_dav, pd_req;

  function automatic bit writable(int k, int unsigned a);
    if (k == 0) return 1'b1;
    return MASK_B[a];
  endfunction

  task automatic model_reset();
    ph = MIdle; m_ptr = 0; m_rd = 0; n_req = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_reg[k][i] = RV[8*i +: 8];
      m_pulse[k] = '0;
      m_dout[k]  = 8'h00;
    end
    prv_bsy = 1'b1; prv_dav = 1'b0; prv_req = 1'b0;
    pd_bsy_rise = 0; pd_bsy_fall = 0; pd_dav = 0; pd_req = 0;
  endtask

  task automatic read_out();
    for (int k = 0; k < 2; k++) m_dout[k] = m_reg[k][m_rd];
    m_rd = (m_rd + 1) % 16;
  endtask

  task automatic model_step();
    bit wr_now;
    int unsigned wa;
    wr_now = 0;
    wa = 0;
    for (int k = 0; k < 2; k++) m_pulse[k] = '0;
    case (ph)
      MIdle: if (pd_bsy_rise) begin ph = MOpen; m_rd = m_ptr; n_req = 0; end
      MOpen: begin
        if (pd_dav) begin
          m_ptr = int'(sdo) % 16;
          ph = MWr;
        end else if (pd_req) begin
          read_out();
          n_req++;
          if (n_req == 2) ph = MRd;
        end
      end
      MWr: if (pd_dav) begin wr_now = 1; wa = m_ptr; m_ptr = (m_ptr + 1) % 16; end
      MRd: if (pd_req) read_out();
      default: ;
    endcase
    if (pd_bsy_fall) ph = MIdle;
    for (int k = 0; k < 2; k++) begin
      bit i2c_hit;
      i2c_hit = wr_now && writable(k, wa);
      if (sys_we && !(i2c_hit && wa == int'(sys_waddr))) m_reg[k][sys_waddr] = sys_wdata;
      if (i2c_hit) begin
        m_reg[k][wa] = sdo;
        m_pulse[k][wa] = 1'b1;
      end
    end
    pd_bsy_rise = busy & ~prv_bsy;
    pd_bsy_fall = ~busy & prv_bsy;
    pd_dav      = dav & ~prv_dav;
    pd_req      = req & ~prv_req;
    prv_bsy = busy; prv_dav = dav; prv_req = req;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_inst(input int k, input logic [127:0] flat, input logic [7:0] dout,
                          input logic [15:0] pulse, input logic [3:0] p, input logic drop);
    logic [127:0] ef;
    bit ed;
    for (int i = 0; i < 16; i++) ef[8*i +: 8] = m_reg[k][i];
    ed = sys_we && ph == MWr && pd_dav && writable(k, m_ptr) && int'(sys_waddr) == m_ptr;
    check($sformatf("reg_flat[%0d]", k), flat, ef);
    check($sformatf("slv_data_i[%0d]", k), {120'b0, dout}, {120'b0, m_dout[k]});
    check($sformatf("reg_wr_pulse[%0d]", k), {112'b0, pulse}, {112'b0, m_pulse[k]});
    check($sformatf("ptr[%0d]", k), {124'b0, p}, 128'(m_ptr));
    check($sformatf("sys_drop[%0d]", k), {127'b0, drop}, {127'b0, ed});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, flat_a, dout_a, pulse_a, ptr_a, drop_a);
      cmp_inst(1, flat_b, dout_b, pulse_b, ptr_b, drop_b);
    end
  end

  // ---------------- slave-side stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_t();
    busy = 1'b1; step(3);
  endtask

  task automatic stop_t();
    busy = 1'b0; step(4);
  endtask

  // Optional system write lands on the same edge as this byte's register write.
  task automatic wr_byte(input logic [7:0] b, input bit sw, input logic [3:0] sa,
                         input logic [7:0] sd, output logic [15:0] pa, output logic [15:0] pb,
                         output logic da, output logic db);
    sdo = b;
    dav = 1'b1;
    step(1);
    sys_we = sw; sys_waddr = sa; sys_wdata = sd;
    #3;
    da = drop_a; db = drop_b;
    step(1);
    sys_we = 1'b0;
    pa = pulse_a; pb = pulse_b;
    dav = 1'b0;
    step(4);
  endtask

  task automatic wr(input logic [7:0] b);
    logic [15:0] pa, pb;
    logic da, db;
    wr_byte(b, 1'b0, 4'h0, 8'h00, pa, pb, da, db);
  endtask

  task automatic rd_byte(output logic [7:0] va);
    req = 1'b1;
    step(2);
    va = dout_a;
    req = 1'b0;
    step(4);
  endtask

  initial begin
    logic [15:0] pa, pb;
    logic da, db;
    logic [7:0] v;

    step(3);
    check("reset flat", flat_a, 128'h3C_0000);
    check("reset dout", {120'b0, dout_a}, 128'h0);
    check("reset ptr", {124'b0, ptr_a}, 128'h0);
    rst_n = 1'b1;
    step(2);

    // write burst
    start_t();
    wr_byte(8'h03, 1'b0, 4'h0, 8'h00, pa, pb, da, db);
    check("ptr byte no pulse", {112'b0, pa}, 128'h0);
    wr_byte(8'hA5, 1'b0, 4'h0, 8'h00, pa, pb, da, db);
    check("burst pulse0", {112'b0, pa}, 128'h0008);
    wr_byte(8'h5A, 1'b0, 4'h0, 8'h00, pa, pb, da, db);
    check("burst pulse1", {112'b0, pa}, 128'h0010);
    stop_t();
    check("burst ptr", {124'b0, ptr_a}, 128'd5);
    check("burst reg3/4", {112'b0, flat_a[39:24]}, 128'h5AA5);

    // pointer wrap
    start_t(); wr(8'hFF); wr(8'h11); wr(8'h22); stop_t();
    check("wrap reg15", {120'b0, flat_a[127:120]}, 128'h11);
    check("wrap reg0", {120'b0, flat_a[7:0]}, 128'h22);
    check("wrap ptr", {124'b0, ptr_a}, 128'd1);

    // read twice from pointer 3
    start_t(); wr(8'h03); stop_t();
    for (int t = 0; t < 2; t++) begin
      start_t();
      rd_byte(v); check("read b0", {120'b0, v}, 128'hA5);
      rd_byte(v); check("read b1", {120'b0, v}, 128'h5A);
      rd_byte(v); check("read b2", {120'b0, v}, 128'h00);
      stop_t();
      check("read ptr", {124'b0, ptr_a}, 128'd3);
    end

    // standalone system write
    sys_we = 1'b1; sys_waddr = 4'h7; sys_wdata = 8'h5C;
    step(1);
    sys_we = 1'b0;
    check("sys reg7", {120'b0, flat_a[63:56]}, 128'h5C);

    // mask and collision
    start_t();
    wr(8'h04);
    wr_byte(8'h77, 1'b1, 4'h9, 8'h42, pa, pb, da, db);
    check("mask pulse b", {112'b0, pb}, 128'h0);
    check("mask pulse a", {112'b0, pa}, 128'h0010);
    check("no-collide drop", {127'b0, da}, 128'h0);
    wr_byte(8'h88, 1'b1, 4'h5, 8'hEE, pa, pb, da, db);
    check("collide drop a", {127'b0, da}, 128'h1);
    check("collide drop b", {127'b0, db}, 128'h1);
    stop_t();
    check("mask reg4 b", {120'b0, flat_b[39:32]}, 128'h00);
    check("reg5 b", {120'b0, flat_b[47:40]}, 128'h88);
    check("reg5 a", {120'b0, flat_a[47:40]}, 128'h88);
    check("reg9 a", {120'b0, flat_a[79:72]}, 128'h42);
    check("drop cleared", {127'b0, drop_a}, 128'h0);

    // reset in the middle of a write
    start_t();
    wr(8'h02);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    wr(8'h33); wr(8'h44);
    check("midrst ptr", {124'b0, ptr_a}, 128'h0);
    check("midrst flat", flat_a, 128'h3C_0000);
    stop_t();
    start_t(); wr(8'h01); wr(8'h99); stop_t();
    check("after rst reg1", {120'b0, flat_a[15:8]}, 128'h99);
    check("after rst ptr", {124'b0, ptr_a}, 128'd2);

    step(3);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Register-file controller placed behind the `i2c_slave` block. It turns the slave's byte-level flags (`busy`, `data_available`, `data_request`) into a pointer-addressed bank of 8-bit registers. The first written byte of a transaction sets the pointer; later written bytes go to consecutive registers with auto-increment. Read transactions stream registers from the pointer onward. A system-side write port lets local logic update registers, and I2C writes win any collision.

## Interface
- `REG_COUNT`, 16: number of 8-bit registers; power of two, 2..128.
- `ADDR_W`, `$clog2(REG_COUNT)`: pointer width.
- `WR_MASK`, all ones (`REG_COUNT` bits): bit i set means register i is writable over I2C.
- `RESET_VAL`, 0 (`REG_COUNT*8` bits): reset contents; register i is `[8i+7:8i]`.

Ports:
- `clk` in 1: system clock; `i2c_slave` runs on the same clock.
- `rst` in 1: reset, asynchronous, active-low.
- `slv_busy` in 1: from slave `busy`.
- `slv_data_available` in 1: from slave `data_available`.
- `slv_data_request` in 1: from slave `data_request`.
- `slv_data_o` in 8: from slave `data_o`.
- `slv_data_i` out 8: to slave `data_i`; registered.
- `sys_we` in 1: system write strobe.
- `sys_waddr` in `ADDR_W`: system write address.
- `sys_wdata` in 8: system write data.
- `sys_drop` out 1: one-cycle pulse when a system write is discarded due to a collision.
- `reg_flat` out `REG_COUNT*8`: all register contents.
- `reg_wr_pulse` out `REG_COUNT`: bit i pulses for one cycle when register i is written over I2C.
- `ptr` out `ADDR_W`: current register pointer.

## Operation
- **Input capture:** `slv_busy`, `slv_data_available` and `slv_data_request` each pass through two register stages (q, qq). Edges are detected as q & ~qq (rise) or ~q & qq (fall).
  - `bsy` stages reset to 1, so a transaction already in progress at reset release is never seen as a start.
  - `dav` and `req` stages reset to 0.
- **FSM states:** IDLE, OPEN, WR, RD.
- **IDLE:**
  - `bsy` rise → OPEN.
  - `rd_ptr` <= `ptr`.
- **OPEN** (addressed; direction not yet known):
  - `req` rise: `slv_data_i` <= reg[`rd_ptr`], `rd_ptr`++. If this is the second `req` rise in OPEN → RD (a read is confirmed).
  - `dav` rise: `ptr` <= `slv_data_o[ADDR_W-1:0]` (upper bits ignored) → WR.
- **WR:**
  - Each `dav` rise: if `WR_MASK[ptr]`, reg[`ptr`] <= `slv_data_o` and `reg_wr_pulse[ptr]` = 1 for one cycle.
  - Masked bytes are dropped with no pulse.
  - `ptr` <= `ptr`+1 in both cases.
- **RD:**
  - Each `req` rise: `slv_data_i` <= reg[`rd_ptr`], `rd_ptr`++.
  - `ptr` itself is never changed by reads, so repeated read transactions restart at `ptr`.
- **Any state:** `bsy` fall → IDLE. This covers STOP, a non-addressed transaction, and a transaction abandoned after the pointer byte only.
- **Wrap-around:** all pointer arithmetic is modulo `REG_COUNT`, so `REG_COUNT-1` + 1 = 0.
- **System writes:**
  - When `sys_we` is high, reg[`sys_waddr`] <= `sys_wdata`, unless an I2C write to the same register occurs in the same cycle.
  - On that collision the I2C value is stored and `sys_drop` pulses.
  - A system write to a different register in the same cycle as an I2C write completes normally.
  - System writes ignore `WR_MASK`.
- **Unexpected events:** `dav` rise in RD and `req` rise in WR are ignored.

## Timing
- **Reset values:** regs = `RESET_VAL`, `ptr` = 0, `rd_ptr` = 0, `slv_data_i` = 8'h00, `sys_drop` = 0, `reg_wr_pulse` = 0, state IDLE.
- **Write latency:** `slv_data_available` rising at clk edge n gives `reg_flat` and `reg_wr_pulse` updated after edge n+2. The slave updates `data_o` at edge n+1, so `slv_data_o` is stable when sampled.
- **Read latency:** `slv_data_request` rising at clk edge n gives `slv_data_i` valid after edge n+2. This is far inside the SCL low phase before the slave loads its send buffer; this requires f_clk ≥ 8 × f_SCL.
- **`sys_we` / `sys_drop`:**
  - A system write takes effect at the next edge.
  - `sys_drop` is asserted during the same cycle as the colliding I2C write (combinational from the write enables) and lasts one cycle.
- **Reset mid-transaction:** state returns to IDLE immediately. The remaining bytes of that transaction are ignored because no `bsy` rise is seen; the next transaction after `bsy` falls and rises works normally.

## Test plan
- **Reset:** `REG_COUNT`=16, `RESET_VAL` reg2=8'h3C → `reg_flat` reg2=3C, others 00; `slv_data_i`=00, `ptr`=0.
- **Write burst:** bytes 0x03, 0xA5, 0x5A → reg3=A5, reg4=5A; `reg_wr_pulse` = 0x0008, then 0x0010, one cycle each; `ptr`=5 after STOP.
- **Pointer wrap:** pointer byte 0xFF (upper bits ignored → 0x0F), then 0x11, 0x22 → reg15=11, reg0=22, `ptr`=1.
- **Read:** set `ptr`=3 (write 0x03, STOP), then a 3-byte read with the master ACKing 2 bytes and NACKing the last → `slv_data_i` = A5, 5A, then reg5. A second identical read returns A5 first again; `ptr` stays 3.
- **Mask and collision:**
  - `WR_MASK` bit 4 clear; write 0x04, 0x77, 0x88 → reg4 unchanged, reg5=88, no pulse on bit 4.
  - `sys_we` to reg5 in the exact cycle of the I2C write of 0x88 → reg5=88 and `sys_drop`=1 for one cycle.
- **Reset mid-write:** assert `rst` low after the pointer byte and release while `busy`=1 → the following data bytes are not stored and `ptr`=0. A next transaction writing 0x01, 0x99 gives reg1=99.
